// File: rtl/trig_pkg.sv
// Shared types and defaults for the trigger-pulse generator.
// Imported by the phase counter and the top-level FSM.
package trig_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } trig_state_e;

    localparam int TRIG_MIN_GAP_DEF = 4;

endpackage

// File: rtl/trig_phase_cnt.sv
// Loadable down-counter timing one HIGH or LOW phase.
// Holds at zero until reloaded; o_zero marks the final phase cycle.
module trig_phase_cnt
    import trig_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_val,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/trig_pulse_gen.sv
// Trigger-pulse generator: single pulses, bursts or a continuous train
// with a guaranteed low gap so every edge survives a pulse synchroniser.
module trig_pulse_gen
    import trig_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int BURST_W = 16,
    parameter int MIN_GAP = TRIG_MIN_GAP_DEF
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               i_start,
    input  logic               i_stop,
    input  logic [CNT_W-1:0]   i_period,
    input  logic [CNT_W-1:0]   i_width,
    input  logic [BURST_W-1:0] i_burst,
    output logic               o_pulse,
    output logic               o_busy,
    output logic               o_done,
    output logic [BURST_W-1:0] o_pulse_cnt
);

    trig_state_e        r_state;
    logic [CNT_W-1:0]   r_w;
    logic [CNT_W-1:0]   r_l;
    logic [BURST_W-1:0] r_b;
    logic [BURST_W-1:0] r_cnt;
    logic [BURST_W-1:0] r_emit;
    logic               r_stop;
    logic               r_pulse;
    logic               r_busy;
    logic               r_done;

    logic [CNT_W-1:0]   w_w;
    logic [CNT_W-1:0]   w_l;
    logic [CNT_W-1:0]   w_gap;
    logic [CNT_W:0]     w_diff;
    logic               w_go;
    logic               w_last;
    logic               w_end_low;
    logic               w_zero;
    logic               w_load;
    logic [CNT_W-1:0]   w_load_val;

    // Extra bit on the subtraction exposes period < width as a sign bit.
    assign w_w    = (i_width == '0) ? CNT_W'(1) : i_width;
    assign w_gap  = CNT_W'(MIN_GAP);
    assign w_diff = {1'b0, i_period} - {1'b0, w_w};
    assign w_l    = (w_diff[CNT_W] || (w_diff[CNT_W-1:0] < w_gap))
                  ? w_gap : w_diff[CNT_W-1:0];

    assign w_go      = i_start && !i_stop;
    assign w_last    = (r_b != '0) && (r_emit == r_b);
    assign w_end_low = r_stop || i_stop || w_last;

    always_comb begin
        w_load     = 1'b0;
        w_load_val = '0;
        unique case (r_state)
            ST_IDLE: begin
                w_load     = w_go;
                w_load_val = w_w - CNT_W'(1);
            end
            ST_HIGH: begin
                w_load     = w_zero || i_stop;
                w_load_val = r_l - CNT_W'(1);
            end
            ST_LOW: begin
                w_load     = w_zero && !w_end_low;
                w_load_val = r_w - CNT_W'(1);
            end
            default: begin
                w_load     = 1'b0;
                w_load_val = '0;
            end
        endcase
    end

    trig_phase_cnt #(
        .CNT_W (CNT_W)
    ) u_phase (
        .clk    (clk),
        .rstn   (rstn),
        .i_load (w_load),
        .i_val  (w_load_val),
        .o_zero (w_zero)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_w     <= '0;
            r_l     <= '0;
            r_b     <= '0;
            r_cnt   <= '0;
            r_emit  <= '0;
            r_stop  <= 1'b0;
            r_pulse <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_go) begin
                        r_w     <= w_w;
                        r_l     <= w_l;
                        r_b     <= i_burst;
                        r_cnt   <= BURST_W'(1);
                        r_emit  <= BURST_W'(1);
                        r_stop  <= 1'b0;
                        r_pulse <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (i_stop) begin
                        r_stop <= 1'b1;
                    end
                    if (w_zero || i_stop) begin
                        r_pulse <= 1'b0;
                        r_state <= ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (i_stop) begin
                        r_stop <= 1'b1;
                    end
                    if (w_zero) begin
                        if (w_end_low) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            r_pulse <= 1'b1;
                            r_cnt   <= r_cnt + BURST_W'(1);
                            // Saturate: only compared in burst mode.
                            if (r_emit != '1) begin
                                r_emit <= r_emit + BURST_W'(1);
                            end
                            r_state <= ST_HIGH;
                        end
                    end
                end
                default: begin
                    r_pulse <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_pulse     = r_pulse;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_pulse_cnt = r_cnt;

endmodule

// File: tb/tb_trig_pulse_gen.sv
// Directed bench for trig_pulse_gen with a 4-bit burst counter
// so the continuous-mode wrap is reachable quickly.
module tb_trig_pulse_gen;

    localparam int CNT_W   = 32;
    localparam int BURST_W = 4;
    localparam int MIN_GAP = 4;

    logic               clk = 1'b0;
    logic               rstn;
    logic               i_start;
    logic               i_stop;
    logic [CNT_W-1:0]   i_period;
    logic [CNT_W-1:0]   i_width;
    logic [BURST_W-1:0] i_burst;
    logic               o_pulse;
    logic               o_busy;
    logic               o_done;
    logic [BURST_W-1:0] o_pulse_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    trig_pulse_gen #(
        .CNT_W   (CNT_W),
        .BURST_W (BURST_W),
        .MIN_GAP (MIN_GAP)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .i_start     (i_start),
        .i_stop      (i_stop),
        .i_period    (i_period),
        .i_width     (i_width),
        .i_burst     (i_burst),
        .o_pulse     (o_pulse),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_pulse_cnt (o_pulse_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic cfg(input int w, input int p, input int b);
        i_width  = CNT_W'(w);
        i_period = CNT_W'(p);
        i_burst  = BURST_W'(b);
    endtask

    task automatic start();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    // One pulse: h high cycles then l low cycles, with the expected count.
    task automatic pulse(input string tag, input int h, input int l,
                         input int cnt);
        for (int i = 0; i < h; i++) begin
            chk({tag, "_hi"}, 32'(o_pulse), 32'd1);
            chk({tag, "_cnt"}, 32'(o_pulse_cnt), 32'(cnt));
            tick();
        end
        for (int i = 0; i < l; i++) begin
            chk({tag, "_lo"}, 32'(o_pulse), 32'd0);
            chk({tag, "_busy"}, 32'(o_busy), 32'd1);
            tick();
        end
    endtask

    task automatic done_chk(input string tag, input int cnt);
        chk({tag, "_done"}, 32'(o_done), 32'd1);
        chk({tag, "_idle"}, 32'(o_busy), 32'd0);
        chk({tag, "_pcnt"}, 32'(o_pulse_cnt), 32'(cnt));
    endtask

    initial begin
        rstn    = 1'b0;
        i_start = 1'b0;
        i_stop  = 1'b0;
        cfg(0, 0, 0);
        tick();
        tick();
        chk("rst_pulse", 32'(o_pulse), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_cnt", 32'(o_pulse_cnt), 32'd0);
        rstn = 1'b1;
        tick();

        // Single pulse: 3 high, 7 low.
        cfg(3, 10, 1);
        start();
        pulse("t1", 3, 7, 1);
        done_chk("t1", 1);

        // Restart in the done cycle; period clamps to 2 + 4.
        cfg(2, 4, 3);
        start();
        chk("t2_nodone", 32'(o_done), 32'd0);
        pulse("t2a", 2, 4, 1);
        pulse("t2b", 2, 4, 2);
        pulse("t2c", 2, 4, 3);
        done_chk("t2", 3);
        tick();
        chk("t2_done1cy", 32'(o_done), 32'd0);

        // Zero width/period clamp to W=1, L=MIN_GAP.
        cfg(0, 0, 2);
        start();
        pulse("t3a", 1, 4, 1);
        pulse("t3b", 1, 4, 2);
        done_chk("t3", 2);
        tick();

        // Stop in cycle 2 of a 4-wide HIGH in continuous mode.
        cfg(4, 5, 0);
        start();
        chk("t4_hi1", 32'(o_pulse), 32'd1);
        tick();
        chk("t4_hi2", 32'(o_pulse), 32'd1);
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
        pulse("t4", 0, 4, 1);
        done_chk("t4", 1);
        tick();

        // Continuous train wraps the 4-bit count 15 -> 0.
        cfg(1, 5, 0);
        start();
        repeat (70) tick();
        chk("t5_c15", 32'(o_pulse_cnt), 32'd15);
        chk("t5_p15", 32'(o_pulse), 32'd1);
        repeat (5) tick();
        chk("t5_wrap", 32'(o_pulse_cnt), 32'd0);
        chk("t5_pwrap", 32'(o_pulse), 32'd1);
        chk("t5_busy", 32'(o_busy), 32'd1);
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
        pulse("t5s", 0, 4, 0);
        done_chk("t5", 0);
        tick();

        // Start and stop together: nothing starts.
        cfg(3, 10, 1);
        i_start = 1'b1;
        i_stop  = 1'b1;
        tick();
        i_start = 1'b0;
        i_stop  = 1'b0;
        chk("t6_busy", 32'(o_busy), 32'd0);
        chk("t6_pulse", 32'(o_pulse), 32'd0);
        tick();
        chk("t6_busy2", 32'(o_busy), 32'd0);

        // Start while busy with new config is ignored.
        cfg(3, 10, 1);
        start();
        pulse("t7a", 1, 0, 1);
        cfg(8, 20, 5);
        start();
        pulse("t7b", 1, 7, 1);
        done_chk("t7", 1);
        tick();

        // Async reset mid-HIGH, then a normal run.
        cfg(5, 12, 1);
        start();
        tick();
        chk("t8_hi", 32'(o_pulse), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("t8_apulse", 32'(o_pulse), 32'd0);
        chk("t8_abusy", 32'(o_busy), 32'd0);
        chk("t8_acnt", 32'(o_pulse_cnt), 32'd0);
        chk("t8_adone", 32'(o_done), 32'd0);
        tick();
        rstn = 1'b1;
        tick();
        chk("t8_nodone", 32'(o_done), 32'd0);
        cfg(2, 8, 1);
        start();
        pulse("t8", 2, 6, 1);
        done_chk("t8", 1);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
